// File: rtl/regfile_np.sv
// regfile_np -- multi-read, single-write register file with a sequenced clear.
//
// Register 0 is hardwired to zero: writes to it are dropped and reads of it
// return zero. The storage array has no reset. Leaving reset, and after any
// clr_req seen in IDLE, the block walks registers 1..NREGS-1 and zeroes one
// per clock. ready is low for that whole walk, and every read port returns
// zero while ready is low.
//
// Parameters:
//   XLEN  - register width in bits
//   NREGS - register count (power of two, >= 4)
//   NRD   - number of read ports (1..4)
//   AW    - address width, derived as $clog2(NREGS); not overridable
//
// Ports:
//   clk      - rising-edge clock
//   rst_n    - asynchronous active-low reset (restarts the clear walk)
//   rs_addr  - read addresses, port i at [i*AW +: AW]
//   rs_data  - combinational read data, port i at [i*XLEN +: XLEN]
//   rd_we    - write enable (ignored while clearing)
//   rd_addr  - write address
//   rd_data  - write data
//   clr_req  - one-cycle request to zero the whole file (ignored while clearing)
//   ready    - high when reads are valid and writes are accepted
//
// Build option:
//   REGFILE_NP_BYPASS_EN - when defined, a write in progress is forwarded to
//   any read port that addresses the same register in the same cycle.
//   When undefined, that port sees the old value until the next cycle.
module regfile_np #(
  parameter  int XLEN  = 32,
  parameter  int NREGS = 32,
  parameter  int NRD   = 2,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NRD*AW-1:0]   rs_addr,
  output logic [NRD*XLEN-1:0] rs_data,
  input  logic                rd_we,
  input  logic [AW-1:0]       rd_addr,
  input  logic [XLEN-1:0]     rd_data,
  input  logic                clr_req,
  output logic                ready
);

  typedef enum logic {
    CLEAR,
    IDLE
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic [AW-1:0]   cnt;
  logic [AW-1:0]   cnt_nx;
  logic            clr_we;
  logic            wr_en;
  logic            last;

  logic [XLEN-1:0] mem [NREGS];

  // Next-state logic. cnt only wraps back to 1 on the CLEAR-to-IDLE edge,
  // so it never steps past NREGS-1.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    clr_we   = 1'b0;
    wr_en    = 1'b0;
    last     = (cnt == AW'(NREGS - 1));
    case (state)
      CLEAR: begin
        clr_we = 1'b1;
        if (last) begin
          state_nx = IDLE;
          cnt_nx   = AW'(1);
        end else begin
          cnt_nx = cnt + AW'(1);
        end
      end
      IDLE: begin
        wr_en = rd_we && (rd_addr != '0);
        if (clr_req) begin
          state_nx = CLEAR;
          cnt_nx   = AW'(1);
        end
      end
      default: begin
        state_nx = CLEAR;
        cnt_nx   = AW'(1);
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CLEAR;
      cnt   <= AW'(1);
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // The array has no reset. Writes are gated with rst_n so that an edge
  // arriving while reset is held cannot commit a write.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (clr_we) begin
        mem[cnt] <= '0;
      end else if (wr_en) begin
        mem[rd_addr] <= rd_data;
      end
    end
  end

  assign ready = (state == IDLE);

  // Read ports. Address 0 and the not-ready case both fall through to zero.
  // wr_en already implies IDLE and a non-zero write address, so the forward
  // path never bypasses those guards.
  always_comb begin
    rs_data = '0;
    for (int unsigned i = 0; i < NRD; i++) begin
      if (ready && (rs_addr[i*AW +: AW] != '0)) begin
        rs_data[i*XLEN +: XLEN] = mem[rs_addr[i*AW +: AW]];
      end
`ifdef REGFILE_NP_BYPASS_EN
      if (wr_en && (rs_addr[i*AW +: AW] == rd_addr)) begin
        rs_data[i*XLEN +: XLEN] = rd_data;
      end
`endif
    end
  end

endmodule

// File: doc/regfile_np.md
REGFILE_NP -- requirements
Module: regfile_np

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning register data width in bits.
REQ-002 SHALL have parameter NREGS, default 32, meaning register count; power of two, at least 4.
REQ-003 SHALL have parameter NRD, default 2, meaning read port count, 1..4.
REQ-004 SHALL derive local AW = clog2(NREGS); AW is not overridable.
REQ-005 SHALL have port clk  input  1  rising-edge clock.
REQ-006 SHALL have port rst_n  input  1  reset; one clock, reset asynchronous and active-low.
REQ-007 SHALL have port rs_addr  input  NRD*AW  read addresses; port i at bits [i*AW +: AW].
REQ-008 SHALL have port rs_data  output  NRD*XLEN  read data; port i at bits [i*XLEN +: XLEN].
REQ-009 SHALL have port rd_we  input  1  write enable.
REQ-010 SHALL have port rd_addr  input  AW  write address.
REQ-011 SHALL have port rd_data  input  XLEN  write data.
REQ-012 SHALL have port clr_req  input  1  single-cycle request to zero all registers.
REQ-013 SHALL have port ready  output  1  high when reads are valid and writes are accepted.

Function
REQ-014 SHALL provide combinational reads on every port; rs_data[i] tracks rs_addr[i] within the same cycle.
REQ-015 SHALL return zero for a read of address 0, regardless of state.
REQ-016 SHALL discard writes to address 0.
REQ-017 SHALL implement states CLEAR and IDLE, with ready high exactly in IDLE.
REQ-018 SHALL, in CLEAR, write zero to register cnt on each rising edge, then increment cnt; cnt starts at 1.
REQ-019 SHALL go from CLEAR to IDLE on the edge that clears register NREGS-1, so CLEAR lasts exactly NREGS-1 cycles.
REQ-020 SHALL, in IDLE with rd_we=1 and rd_addr!=0, write rd_data to rd_addr on the rising edge.
REQ-021 SHALL, in IDLE with clr_req=1, go to CLEAR at the next edge with cnt=1; a write in the same cycle is still performed.
REQ-022 SHALL ignore clr_req while in CLEAR; an in-progress clear is not restarted.
REQ-023 SHALL drop rd_we while in CLEAR with no side effect.
REQ-024 SHALL drive all rs_data ports to zero while ready=0.
REQ-025 SHALL allow any number of read ports to use the same address, each returning identical data.
REQ-026 SHALL wrap cnt only through the CLEAR-to-IDLE transition; cnt never exceeds NREGS-1.

Reset
REQ-027 SHALL, while rst_n=0, force state CLEAR, cnt=1, ready=0 and rs_data all zero, asynchronously.
REQ-028 SHALL, after rst_n deasserts, assert ready after exactly NREGS-1 rising edges, with all registers reading zero.
REQ-029 SHALL, on reset asserted mid-CLEAR or mid-write, abort and restart the full clear sequence; no partial write survives as non-zero.
REQ-030 SHALL NOT asynchronously reset the register array; clearing is done only by the CLEAR sequence.

Configuration
REQ-031 SHALL use macro REGFILE_NP_BYPASS_EN, defined, to forward writes to reads: in IDLE, when rd_we=1, rd_addr!=0 and rs_addr[i]==rd_addr, rs_data[i] SHALL equal rd_data in that same cycle.
REQ-032 SHALL, with REGFILE_NP_BYPASS_EN undefined, have rs_data[i] return the pre-write value in that cycle and the new value from the next cycle.

Verification
REQ-033 SHALL cover reset: NREGS=32, release rst_n, count edges -> ready=0 for 31 edges, ready=1 after edge 31, and all 32 addresses read 0.
REQ-034 SHALL cover write/read: write 0xDEADBEEF to x5, then read rs_addr={5,5} next cycle -> both ports 0xDEADBEEF; write 0x1234 to x0 -> x0 reads 0.
REQ-035 SHALL cover bypass: in one cycle write 0xA5A5A5A5 to x7 while port 0 reads x7 -> 0xA5A5A5A5 with the macro defined, old value 0 without it.
REQ-036 SHALL cover clear: fill x1..x31 with index values, pulse clr_req -> ready low for 31 cycles; clr_req and rd_we to x3 during CLEAR are ignored; all registers read 0 afterward.
REQ-037 SHALL cover reset mid-clear: assert rst_n=0 at CLEAR cycle 10 for one cycle -> ready returns 31 edges after release, and all registers read 0.
REQ-038 SHALL cover parameters: XLEN=64, NREGS=16, NRD=3; write 0xFFFF_0000_FFFF_0000 to x15 -> all three ports read it at addr 15; reset-to-ready takes 15 edges.
